pipe_skid_reg: RTL and testbench



---
 rtl/pipe_skid_reg_if.sv | 24 ++
 rtl/pipe_skid_reg.sv | 96 +++++++++
 tb/tb_pipe_skid_reg.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage, including the flush strobe.
// master = upstream/downstream environment side, slave = the stage register itself.
`timescale 1ns/1ps
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a two-entry skid buffer and registered in_ready.
// Define PIPE_SKID_PERF_EN to build the saturating stall counter; otherwise stall_cnt is tied to 0.
`timescale 1ns/1ps
module pipe_skid_reg #(
    parameter int               XLEN      = 32,
    parameter int               WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int               CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_skid_reg_if.slave     bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic             main_v, main_v_n;
    logic             skid_v, skid_v_n;
    logic [WIDTH-1:0] main_d, main_d_n;
    logic [WIDTH-1:0] skid_d, skid_d_n;
    logic             in_fire;

    // in_ready depends only on the skid flop, never on out_ready, so no combinational ready path.
    assign bus.in_ready  = ~skid_v;
    assign in_fire       = bus.in_valid & ~skid_v;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_v ? main_d : FLUSH_VAL;
    assign occupancy     = {1'b0, main_v} + {1'b0, skid_v};

    always_comb begin
        main_v_n = main_v;
        main_d_n = main_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (bus.flush) begin
            main_v_n = 1'b0;
            main_d_n = FLUSH_VAL;
            skid_v_n = 1'b0;
            skid_d_n = FLUSH_VAL;
        end else if (!main_v || bus.out_ready) begin
            // Main is free this cycle: the skid entry always drains first to keep FIFO order.
            if (skid_v) begin
                main_v_n = 1'b1;
                main_d_n = skid_d;
                if (in_fire) begin
                    skid_v_n = 1'b1;
                    skid_d_n = bus.in_data;
                end else begin
                    skid_v_n = 1'b0;
                end
            end else if (in_fire) begin
                main_v_n = 1'b1;
                main_d_n = bus.in_data;
                skid_v_n = 1'b0;
            end else begin
                main_v_n = 1'b0;
                skid_v_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_v_n = 1'b1;
            skid_d_n = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= FLUSH_VAL;
            skid_d <= FLUSH_VAL;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_d_n;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_q;

    // Counts cycles where downstream stalls a valid payload; survives flush, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (main_v && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg: reset, streaming, back-pressure, flush, skid drain order, stall counter.
// Stall-counter expectations follow PIPE_SKID_PERF_EN when the macro is defined for the build.
`timescale 1ns/1ps
module tb_pipe_skid_reg;

    localparam int               WIDTH     = 8;
    localparam int               CNT_W     = 4;
    localparam logic [WIDTH-1:0] FLUSH_VAL = 8'hEE;

    logic             clk;
    logic             rst_n;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    int               checkCount;
    int               failCount;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                                 input logic ready, input logic fl);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        bus.flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [CNT_W-1:0] satCnt;
        checkCount = 0;
        failCount  = 0;
`ifdef PIPE_SKID_PERF_EN
        satCnt = {CNT_W{1'b1}};
`else
        satCnt = '0;
`endif
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        $display("[TB] reset state");
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'(FLUSH_VAL));
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("[TB] streaming 0x10..0x13");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            step();
            checkOutput("stream_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stream_out_data", 32'(bus.out_data), 32'h10 + 32'(i));
            checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("stream_drained_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("stream_drained_data", 32'(bus.out_data), 32'(FLUSH_VAL));
        checkOutput("stream_drained_occ", 32'(occupancy), 32'd0);
        checkOutput("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("[TB] back-pressure 0xA, 0xB");
        applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0);
        step();
        checkOutput("bp_c1_data", 32'(bus.out_data), 32'h0A);
        checkOutput("bp_c1_occ", 32'(occupancy), 32'd1);
        applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0);
        step();
        checkOutput("bp_c2_occ", 32'(occupancy), 32'd2);
        checkOutput("bp_c2_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_c2_data", 32'(bus.out_data), 32'h0A);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkOutput("bp_c3_data", 32'(bus.out_data), 32'h0A);
        checkOutput("bp_c3_occ", 32'(occupancy), 32'd2);
        step();
        checkOutput("bp_c4_data", 32'(bus.out_data), 32'h0A);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("bp_c5_data", 32'(bus.out_data), 32'h0B);
        checkOutput("bp_c5_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_c5_occ", 32'(occupancy), 32'd1);
        step();
        checkOutput("bp_c6_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] flush with both entries full");
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        step();
        checkOutput("flush_pre_occ", 32'(occupancy), 32'd2);
        applyStimulus(1'b1, 8'h0C, 1'b0, 1'b1);
        step();
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_out_data", 32'(bus.out_data), 32'(FLUSH_VAL));
        checkOutput("flush_occ", 32'(occupancy), 32'd0);
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 8'h0C, 1'b1, 1'b1);
        step();
        checkOutput("flush_drop_in_fire", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("flush_no_0c_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_no_0c_data", 32'(bus.out_data), 32'(FLUSH_VAL));

        $display("[TB] skid drains before new input");
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
        step();
        checkOutput("order_full_occ", 32'(occupancy), 32'd2);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
        step();
        checkOutput("order_skid_to_main", 32'(bus.out_data), 32'h32);
        checkOutput("order_occ_after_drain", 32'(occupancy), 32'd1);
        checkOutput("order_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        checkOutput("order_new_input", 32'(bus.out_data), 32'h33);
        checkOutput("order_occ_stream", 32'(occupancy), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        checkOutput("order_empty", 32'(occupancy), 32'd0);

        $display("[TB] stall counter saturation");
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (20) step();
        checkOutput("stall_cnt_sat", 32'(stall_cnt), 32'(satCnt));
        checkOutput("stall_held_data", 32'(bus.out_data), 32'h44);
        applyStimulus(1'b1, 8'h45, 1'b0, 1'b1);
        step();
        checkOutput("stall_cnt_survives_flush", 32'(stall_cnt), 32'(satCnt));

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 8'h51, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b0);
        step();
        checkOutput("areset_pre_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("areset_out_data", 32'(bus.out_data), 32'(FLUSH_VAL));
        checkOutput("areset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("areset_occ", 32'(occupancy), 32'd0);
        checkOutput("areset_stall_cnt", 32'(stall_cnt), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("areset_after_release", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
